ddr_capture_seq: RTL and testbench

DDR_CAPTURE_SEQ -- requirements
Module: ddr_capture_seq

---
 rtl/ddr_capture_seq.sv | 154 +++++++++++++++
 tb/tb_ddr_capture_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_capture_seq.sv
// Triggered capture sequencer: streams valid samples into a circular capture
// memory before a trigger, then stores a programmed number of post-trigger
// samples and stops with done_o set.
module ddr_capture_seq #(
  parameter int g_addr_width = 6,
  parameter int g_data_width = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    arm_i,
  input  logic                    abort_i,
  input  logic                    trig_i,
  input  logic [g_addr_width-1:0] post_count_i,
  input  logic                    sample_valid_i,
  input  logic [g_data_width-1:0] sample_dat_i,
  output logic [g_addr_width-1:0] mem_adr_o,
  output logic                    mem_we_o,
  output logic [g_data_width-1:0] mem_dat_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    wrapped_o,
  output logic [g_addr_width-1:0] trig_adr_o
);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_POST, S_DONE} state_t;

  state_t                  r_state,   w_state_nx;
  logic [g_addr_width-1:0] r_wptr,    w_wptr_nx;
  logic [g_addr_width-1:0] r_remain,  w_remain_nx;
  logic                    r_tpend,   w_tpend_nx;
  logic                    r_done,    w_done_nx;
  logic                    r_wrapped, w_wrapped_nx;
  logic [g_addr_width-1:0] r_tadr,    w_tadr_nx;
  logic                    r_we,      w_we_nx;
  logic [g_addr_width-1:0] r_adr,     w_adr_nx;
  logic [g_data_width-1:0] r_dat,     w_dat_nx;
  logic                    w_write;
  logic                    w_final;

  // State and datapath registers, cleared asynchronously by rst_i
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_wptr    <= '0;
      r_remain  <= '0;
      r_tpend   <= 1'b0;
      r_done    <= 1'b0;
      r_wrapped <= 1'b0;
      r_tadr    <= '0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_wptr    <= w_wptr_nx;
      r_remain  <= w_remain_nx;
      r_tpend   <= w_tpend_nx;
      r_done    <= w_done_nx;
      r_wrapped <= w_wrapped_nx;
      r_tadr    <= w_tadr_nx;
      r_we      <= w_we_nx;
      r_adr     <= w_adr_nx;
      r_dat     <= w_dat_nx;
    end
  end

  // Next-state, counter and write-port decode; abort overrides everything
  always_comb begin
    w_state_nx   = r_state;
    w_wptr_nx    = r_wptr;
    w_remain_nx  = r_remain;
    w_tpend_nx   = r_tpend;
    w_done_nx    = r_done;
    w_wrapped_nx = r_wrapped;
    w_tadr_nx    = r_tadr;
    w_we_nx      = 1'b0;
    w_adr_nx     = r_adr;
    w_dat_nx     = r_dat;
    w_write      = 1'b0;
    w_final      = 1'b0;

    if (abort_i) begin
      w_state_nx   = S_IDLE;
      w_done_nx    = 1'b0;
      w_wrapped_nx = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (arm_i) begin
            w_state_nx   = S_PRE;
            w_wptr_nx    = '0;
            w_remain_nx  = post_count_i;
            w_tpend_nx   = 1'b0;
            w_done_nx    = 1'b0;
            w_wrapped_nx = 1'b0;
          end
        end
        S_PRE: begin
          if (sample_valid_i) begin
            w_write = 1'b1;
            if (&r_wptr) w_wrapped_nx = 1'b1;
          end
          if (trig_i) begin
            w_tadr_nx = r_wptr;
            if (sample_valid_i) begin
              // Trigger sample written now; a zero post count finishes here
              w_tpend_nx = 1'b0;
              if (r_remain == '0) w_final = 1'b1;
              else                w_state_nx = S_POST;
            end else begin
              // Next valid sample becomes the trigger sample
              w_tpend_nx = 1'b1;
              w_state_nx = S_POST;
            end
          end
        end
        S_POST: begin
          if (sample_valid_i) begin
            w_write = 1'b1;
            if (r_tpend) begin
              w_tpend_nx = 1'b0;
              if (r_remain == '0) w_final = 1'b1;
            end else begin
              w_remain_nx = r_remain - 1'b1;
              if (r_remain == {{(g_addr_width-1){1'b0}}, 1'b1}) w_final = 1'b1;
            end
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end

    if (w_final) begin
      w_state_nx = S_DONE;
      w_done_nx  = 1'b1;
    end

    if (w_write) begin
      w_we_nx   = 1'b1;
      w_adr_nx  = r_wptr;
      w_dat_nx  = sample_dat_i;
      w_wptr_nx = r_wptr + 1'b1;
    end
  end

  assign mem_adr_o  = r_adr;
  assign mem_we_o   = r_we;
  assign mem_dat_o  = r_dat;
  assign busy_o     = (r_state == S_PRE) || (r_state == S_POST);
  assign done_o     = r_done;
  assign wrapped_o  = r_wrapped;
  assign trig_adr_o = r_tadr;

endmodule

// File: tb/tb_ddr_capture_seq.sv
// Randomized + directed bench for ddr_capture_seq with a capture-level
// reference model feeding a write scoreboard.
module tb_ddr_capture_seq;
  localparam int AW    = 6;
  localparam int DW    = 64;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          arm_i = 1'b0, abort_i = 1'b0, trig_i = 1'b0, sample_valid_i = 1'b0;
  logic [AW-1:0] post_count_i = '0;
  logic [DW-1:0] sample_dat_i = '0;
  logic [AW-1:0] mem_adr_o, trig_adr_o;
  logic          mem_we_o, busy_o, done_o, wrapped_o;
  logic [DW-1:0] mem_dat_o;

  ddr_capture_seq #(.g_addr_width(AW), .g_data_width(DW)) dut (
    .clk_i(clk), .rst_i(rst_i), .arm_i(arm_i), .abort_i(abort_i), .trig_i(trig_i),
    .post_count_i(post_count_i), .sample_valid_i(sample_valid_i), .sample_dat_i(sample_dat_i),
    .mem_adr_o(mem_adr_o), .mem_we_o(mem_we_o), .mem_dat_o(mem_dat_o), .busy_o(busy_o),
    .done_o(done_o), .wrapped_o(wrapped_o), .trig_adr_o(trig_adr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          fin;
    int          adr;
    logic [DW-1:0] dat;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  // Reference model: a capture is "active" between an accepted arm and the
  // write of its last post-trigger sample.
  bit  m_active, m_trig, m_tsample, m_done, m_wrapped;
  int  m_ptr, m_left, m_tadr;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_trig = 0; m_tsample = 0; m_done = 0; m_wrapped = 0;
    m_ptr = 0; m_left = 0; m_tadr = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit a, input bit ab, input bit tg, input bit v,
                            input logic [DW-1:0] d, input int pc);
    bit was_trig, fin;
    wr_t w;
    if (ab) begin
      m_active = 0; m_done = 0; m_wrapped = 0;
    end else if (!m_active) begin
      if (a) begin
        m_active = 1; m_trig = 0; m_tsample = 0; m_ptr = 0; m_left = pc;
        m_done = 0; m_wrapped = 0;
      end
    end else begin
      was_trig = m_trig;
      if (!m_trig && tg) begin
        m_trig = 1;
        m_tadr = m_ptr;
      end
      if (v) begin
        fin = 0;
        if (m_trig && !m_tsample) begin
          m_tsample = 1;
          fin = (m_left == 0);
        end else if (m_tsample) begin
          m_left--;
          fin = (m_left == 0);
        end
        if (!was_trig && m_ptr == DEPTH - 1) m_wrapped = 1;
        w.fin = fin; w.adr = m_ptr; w.dat = d;
        exp_q.push_back(w);
        m_ptr = (m_ptr + 1) % DEPTH;
        if (fin) begin
          m_active = 0;
          m_done = 1;
        end
      end
    end
  endtask

  // One cycle: check status against model, then drive inputs and advance model
  task automatic step(input bit a, input bit ab, input bit tg, input bit v,
                      input logic [DW-1:0] d, input int pc);
    @(negedge clk);
    chk("busy", busy_o, m_active);
    chk("done", done_o, m_done);
    chk("wrapped", wrapped_o, m_wrapped);
    chk("trig_adr", trig_adr_o, m_tadr);
    arm_i = a; abort_i = ab; trig_i = tg; sample_valid_i = v;
    sample_dat_i = d; post_count_i = AW'(pc);
    model_step(a, ab, tg, v, d, pc);
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  // Monitor: every write strobe must match the oldest expected write
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mem_we_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_adr", mem_adr_o, e.adr);
          chk("wr_dat", mem_dat_o, e.dat);
          chk("wr_done", done_o, e.fin);
        end
      end
    end
  end

  initial begin
    model_reset();
    #12;
    chk("rst_we", mem_we_o, 0);
    chk("rst_adr", mem_adr_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_i = 1'b0;

    // Samples and trigger before any arm are ignored
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, rnd(), 0);

    // Basic capture: 5 pre, trigger sample at 5, 3 post
    step(1, 0, 0, 0, 0, 3);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, rnd(), 0);
    step(0, 0, 1, 1, rnd(), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, rnd(), 0);
    step(0, 0, 0, 1, rnd(), 0);
    chk("c1_tadr", trig_adr_o, 5);
    chk("c1_done", done_o, 1);
    chk("c1_busy", busy_o, 0);

    // Wrap: 70 pre samples then trigger sample at address 6
    step(1, 0, 0, 0, 0, 2);
    for (int i = 0; i < 70; i++) step(0, 0, 0, 1, rnd(), 0);
    step(0, 0, 1, 1, rnd(), 0);
    step(0, 0, 0, 1, rnd(), 0);
    step(0, 0, 0, 1, rnd(), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("c2_tadr", trig_adr_o, 6);
    chk("c2_wrapped", wrapped_o, 1);
    chk("c2_done", done_o, 1);

    // Zero post count, trigger without sample
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, rnd(), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("c3_tadr", trig_adr_o, 0);
    chk("c3_done", done_o, 1);

    // Abort together with trigger after 10 samples
    step(1, 0, 0, 0, 0, 4);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, rnd(), 0);
    step(0, 1, 1, 1, rnd(), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, rnd(), 0);
    chk("c4_tadr", trig_adr_o, 0);
    chk("c4_done", done_o, 0);

    // Arm+trigger in IDLE, re-arm during PRE
    step(1, 0, 1, 0, 0, 2);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, rnd(), 0);
    step(1, 0, 0, 1, rnd(), 0);
    step(0, 0, 0, 1, rnd(), 0);
    step(0, 0, 1, 1, rnd(), 0);
    step(0, 0, 0, 1, rnd(), 0);
    step(0, 0, 0, 1, rnd(), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("c5_tadr", trig_adr_o, 6);

    // Asynchronous reset in POST while a write is on the port
    step(1, 0, 0, 0, 0, 5);
    step(0, 0, 1, 1, rnd(), 0);
    step(0, 0, 0, 1, rnd(), 0);
    @(posedge clk);
    #2;
    chk("c6_we_before", mem_we_o, 1);
    rst_i = 1'b1;
    #1;
    chk("c6_we", mem_we_o, 0);
    chk("c6_adr", mem_adr_o, 0);
    chk("c6_dat", mem_dat_o, 0);
    chk("c6_busy", busy_o, 0);
    chk("c6_done", done_o, 0);
    chk("c6_wrapped", wrapped_o, 0);
    chk("c6_tadr", trig_adr_o, 0);
    model_reset();
    @(negedge clk);
    arm_i = 0; abort_i = 0; trig_i = 0; sample_valid_i = 0;
    #2;
    rst_i = 1'b0;
    step(0, 0, 0, 1, rnd(), 0);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 1, 1, rnd(), 0);
    step(0, 0, 0, 1, rnd(), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("c6_restart_done", done_o, 1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit a, ab, tg, v;
      int pc;
      a  = ($urandom_range(0, 19) == 0);
      ab = ($urandom_range(0, 249) == 0);
      tg = ($urandom_range(0, 29) == 0);
      v  = ($urandom_range(0, 3) != 0);
      pc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 6);
      step(a, ab, tg, v, rnd(), pc);
    end
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
